// File: rtl/keypad_scan_ctrl.sv
// 4x4 active-low matrix keypad scanner with frame-based debounce.
// Emits the last confirmed key as a 16-bit one-hot code (bit = row*4 + col).
module keypad_scan_ctrl #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_n,
  output logic [3:0]  col_n,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_down,
  output logic [1:0]  state_dbg
);

  localparam int              DW         = $clog2(SCAN_DIV);
  localparam logic [DW-1:0]   DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [3:0]      DEB_N      = 4'(DEBOUNCE_SCANS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    DEB     = 2'd1,
    PRESSED = 2'd2,
    REL     = 2'd3
  } state_t;

  logic [3:0]    row_s1_q, row_s2_q;
  logic [DW-1:0] dwell_q;
  logic [1:0]    col_q;
  logic [15:0]   acc_q;
  state_t        state_q;
  logic [3:0]    cnt_q;
  logic [15:0]   cand_q;
  logic [15:0]   onehot_q;
  logic          valid_q;
  logic          down_q;

  logic [15:0]   hits_d;
  logic [15:0]   frame_d;
  logic          sample_d;
  logic          frame_end_d;
  logic          f_zero_d;
  logic          f_single_d;
  logic [3:0]    cnt_inc_d;

  // Rows seen low in the current column, already mapped to key indices.
  always_comb begin
    hits_d = '0;
    for (int r = 0; r < 4; r++) begin
      if (!row_s2_q[r]) hits_d[{r[1:0], col_q}] = 1'b1;
    end
  end

  assign sample_d    = (dwell_q == DWELL_LAST);
  assign frame_end_d = sample_d && (col_q == 2'd3);
  assign frame_d     = acc_q | hits_d;
  assign f_zero_d    = (frame_d == 16'd0);
  assign f_single_d  = !f_zero_d && ((frame_d & (frame_d - 16'd1)) == 16'd0);
  assign cnt_inc_d   = cnt_q + 4'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_s1_q <= 4'b1111;
      row_s2_q <= 4'b1111;
    end else begin
      row_s1_q <= row_n;
      row_s2_q <= row_s1_q;
    end
  end

  // Free-running column scan; independent of the debounce FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_q <= '0;
      col_q   <= 2'd0;
      acc_q   <= '0;
    end else if (sample_d) begin
      dwell_q <= '0;
      col_q   <= col_q + 2'd1;
      acc_q   <= (col_q == 2'd3) ? 16'd0 : frame_d;
    end else begin
      dwell_q <= dwell_q + DW'(1);
    end
  end

  assign col_n = ~(4'b0001 << col_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= 4'd0;
      cand_q   <= 16'd0;
      onehot_q <= 16'd0;
      valid_q  <= 1'b0;
      down_q   <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (frame_end_d) begin
        unique case (state_q)
          IDLE: begin
            if (f_single_d) begin
              cand_q <= frame_d;
              if (DEB_N == 4'd1) begin
                onehot_q <= frame_d;
                valid_q  <= 1'b1;
                down_q   <= 1'b1;
                cnt_q    <= 4'd0;
                state_q  <= PRESSED;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= DEB;
              end
            end
          end
          DEB: begin
            if (frame_d == cand_q) begin
              if (cnt_inc_d == DEB_N) begin
                onehot_q <= cand_q;
                valid_q  <= 1'b1;
                down_q   <= 1'b1;
                cnt_q    <= 4'd0;
                state_q  <= PRESSED;
              end else begin
                cnt_q <= cnt_inc_d;
              end
            end else begin
              // A different key only becomes a candidate from the next frame.
              cnt_q   <= 4'd0;
              state_q <= IDLE;
            end
          end
          PRESSED: begin
            if (f_zero_d) begin
              if (DEB_N == 4'd1) begin
                down_q  <= 1'b0;
                cnt_q   <= 4'd0;
                state_q <= IDLE;
              end else begin
                cnt_q   <= 4'd1;
                state_q <= REL;
              end
            end
          end
          REL: begin
            if (f_zero_d) begin
              if (cnt_inc_d == DEB_N) begin
                down_q  <= 1'b0;
                cnt_q   <= 4'd0;
                state_q <= IDLE;
              end else begin
                cnt_q <= cnt_inc_d;
              end
            end else begin
              cnt_q   <= 4'd0;
              state_q <= PRESSED;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  assign onehot    = onehot_q;
  assign key_valid = valid_q;
  assign key_down  = down_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// Bench for keypad_scan_ctrl: emulated key matrix, frame-level debounce model,
// scoreboard of expected key_valid pulses checked by an independent monitor.
module tb_keypad_scan_ctrl;

  localparam int SCAN_DIV = 4;
  localparam int DEB      = 3;
  localparam int FRAME    = 4 * SCAN_DIV;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [15:0] onehot;
  logic        key_valid;
  logic        key_down;
  logic [1:0]  state_dbg;

  logic [15:0] keys;
  int          cyc;
  int          frame_no;
  int          n_checks;
  int          n_fail;

  // Expected pulses: code and the cycle (edges since reset release) it must appear in.
  logic [15:0] exp_q[$];
  logic [31:0] exp_cyc_q[$];

  // Debounce reference state, expressed as frame counts.
  logic        m_pressed;
  logic [15:0] m_cand;
  logic [15:0] m_onehot;
  int          m_run;
  int          m_zeros;

  keypad_scan_ctrl #(.SCAN_DIV(SCAN_DIV), .DEBOUNCE_SCANS(DEB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row_n     (row_n),
    .col_n     (col_n),
    .onehot    (onehot),
    .key_valid (key_valid),
    .key_down  (key_down),
    .state_dbg (state_dbg)
  );

  // Clock / reset-relative cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Passive key matrix: a pressed key shorts its row to the driven column.
  always_comb begin
    row_n = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!col_n[c] && keys[r*4+c]) row_n[r] = 1'b0;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: column pattern every cycle, key_valid pulses against the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("col_n", {28'd0, col_n}, {28'd0, ~(4'b0001 << ((cyc / SCAN_DIV) % 4))});
      if (key_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_key_valid", 32'd1, 32'd0);
        end else begin
          chk("key_valid_cycle", cyc, exp_cyc_q.pop_front());
          chk("key_valid_code", {16'd0, onehot}, {16'd0, exp_q.pop_front()});
        end
      end
    end
  end

  function automatic void model_reset();
    m_pressed = 1'b0;
    m_cand    = '0;
    m_onehot  = '0;
    m_run     = 0;
    m_zeros   = 0;
  endfunction

  // One frame of the reference: a key is accepted after DEB identical single-key
  // frames; a break consumes the breaking frame; release needs DEB empty frames.
  function automatic void model_frame(input logic [15:0] f);
    logic single;
    single = (f != 0) && ($countones(f) == 1);
    if (!m_pressed) begin
      if (m_run > 0 && f == m_cand) m_run++;
      else if (m_run > 0)           m_run = 0;
      else if (single) begin
        m_cand = f;
        m_run  = 1;
      end
      if (m_run == DEB) begin
        m_run     = 0;
        m_zeros   = 0;
        m_pressed = 1'b1;
        m_onehot  = m_cand;
        exp_q.push_back(m_cand);
        exp_cyc_q.push_back(32'(frame_no * FRAME));
      end
    end else begin
      if (f == 0) m_zeros++;
      else        m_zeros = 0;
      if (m_zeros == DEB) begin
        m_zeros   = 0;
        m_pressed = 1'b0;
      end
    end
  endfunction

  // Driver: hold a key set for one whole frame, then check the held outputs.
  task automatic run_frame(input logic [15:0] m);
    keys = m;
    frame_no++;
    model_frame(m);
    repeat (FRAME) @(posedge clk);
    #1;
    chk("onehot", {16'd0, onehot}, {16'd0, m_onehot});
    chk("key_down", {31'd0, key_down}, {31'd0, m_pressed});
  endtask

  task automatic hold(input logic [15:0] m, input int n);
    for (int i = 0; i < n; i++) run_frame(m);
  endtask

  task automatic apply_reset(input int mid_cycles);
    repeat (mid_cycles) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_col_n", {28'd0, col_n}, 32'he);
    chk("rst_onehot", {16'd0, onehot}, 32'd0);
    chk("rst_key_down", {31'd0, key_down}, 32'd0);
    chk("rst_key_valid", {31'd0, key_valid}, 32'd0);
    chk("rst_pending_pulses", exp_q.size(), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    model_reset();
    frame_no = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [15:0] m;
    int k1, k2;
    n_checks = 0;
    n_fail   = 0;
    frame_no = 0;
    keys     = '0;
    model_reset();
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    apply_reset(0);

    // Short press of idx 5: rejected
    hold(16'h0020, 2);
    hold(16'h0000, 2);
    // idx 7 held 5 frames, then released 3 frames
    hold(16'h0080, 5);
    hold(16'h0000, 3);

    // Two keys together, then one of them released
    apply_reset(5);
    hold(16'h2008, 6);
    hold(16'h0008, 4);
    hold(16'h0000, 3);

    // Second key while pressed is ignored; fresh press afterwards accepted
    hold(16'h0200, 4);
    hold(16'h4200, 3);
    hold(16'h0000, 3);
    hold(16'h4000, 3);
    hold(16'h0000, 3);

    // Reset in the middle of debounce and while pressed
    hold(16'h0004, 2);
    apply_reset(7);
    hold(16'h0004, 3);
    apply_reset(9);
    hold(16'h0004, 3);
    hold(16'h0000, 3);

    // Randomized key activity, including direct key-to-key switches
    for (int i = 0; i < 30; i++) begin
      k1 = $urandom_range(0, 15);
      k2 = $urandom_range(0, 15);
      m  = 16'd1 << k1;
      if ($urandom_range(0, 4) == 0) m = m | (16'd1 << k2);
      hold(m, $urandom_range(1, 5));
      hold(16'h0000, $urandom_range(0, 3));
    end
    hold(16'h0000, DEB + 1);

    repeat (2) @(negedge clk);
    chk("final_queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
